apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 18 +
 rtl/test_param_pkg.sv | 9 +
 rtl/apb_master.sv | 128 ++++++++++++
 tb/tb_apb_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB master: FSM state encoding and counter sizing helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Width of the ACCESS wait counter; at least one bit so a disabled
    // timeout (TIMEOUT==0) still yields a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/test_param_pkg.sv
// Default bus widths shared by blocks and benches that do not override them.
// Latency: n/a (constants only).
// Backpressure: n/a.
package test_param_pkg;

    localparam int addrWidth = 32;
    localparam int dataWidth = 32;

endpackage

// File: rtl/apb_master.sv
// APB master: turns one valid/ready command into a single APB transfer, with ACCESS timeout and IRQ edge detect.
// Latency: accept N, SETUP N+1, ACCESS N+2, rsp_valid N+3 with zero wait states; 3 cycles per back-to-back transfer.
// Backpressure: cmd_ready only in IDLE; PREADY stretches ACCESS up to TIMEOUT cycles; rsp_valid cannot be stalled.
//
// Ports:
//   PCLK, PRESETN                      clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command request channel
//   rsp_valid/rdata/timeout            one-cycle completion pulse, read data, abort flag
//   PADDR/PWRITE/PSEL/PENABLE/PWDATA   APB request outputs (all registered)
//   PRDATA/PREADY                      APB slave response
//   IRQ -> irq_rise                    slave interrupt level, registered rising-edge pulse
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDRWIDTH = test_param_pkg::addrWidth,
    parameter int DATAWIDTH = test_param_pkg::dataWidth,
    parameter int TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 IRQ,
    output logic                 irq_rise
);

    localparam int              CNTW     = cnt_width(TIMEOUT);
    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t      state;
    logic [CNTW-1:0] wait_cnt;
    logic            irq_q;

    // Decoded from the state register only, so no combinational path from cmd_valid.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            // Completion is a single-cycle pulse.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // Request fields are held from here through the last ACCESS
                        // cycle and keep their values afterwards.
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so a ready slave wins over a
                    // coincident timeout.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        if (!PWRITE) begin
                            rsp_rdata <= PRDATA;
                        end
                        state <= IDLE;
                    end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        wait_cnt    <= wait_cnt + CNTW'(1);
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNTW'(1);
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Rising-edge detector on the slave interrupt level.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            irq_q    <= 1'b0;
            irq_rise <= 1'b0;
        end else begin
            irq_q    <= IRQ;
            irq_rise <= IRQ & ~irq_q;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master (TIMEOUT=4) with a response scoreboard.
// Latency: n/a.
// Backpressure: drives PREADY to exercise wait states and timeout.
module tb_apb_master;

    typedef struct packed {
        logic        to;
        logic [31:0] rdata;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        IRQ;
    logic        irq_rise;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] last_rdata;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDRWIDTH(32), .DATAWIDTH(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .IRQ(IRQ), .irq_rise(irq_rise)
    );

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge PCLK) begin
        if (rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding command (timeout=%0b rdata=%h)",
                         rsp_timeout, rsp_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                if (rsp_timeout !== mon_e.to) begin
                    errors++;
                    $display("FAIL rsp_timeout: got %0b expected %0b", rsp_timeout, mon_e.to);
                end
                checks++;
                if (rsp_rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, mon_e.rdata);
                end
            end
        end
    end

    // Presents a command and waits (bounded) for it to be accepted; the
    // expectation is queued on the accepting edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit push, input exp_t ex);
        bit ok;
        ok = 0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready got 0 expected 1 within 20 cycles");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        if (push) sb_q.push_back(ex);
    endtask

    task automatic test_reset();
        PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++; if (PSEL !== 1'b0)    begin errors++; $display("FAIL rst_psel: got %0b expected 0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable: got %0b expected 0", PENABLE); end
        checks++; if (PWRITE !== 1'b0)  begin errors++; $display("FAIL rst_pwrite: got %0b expected 0", PWRITE); end
        checks++; if (PADDR !== 32'h0)  begin errors++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
        checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata: got %h expected 0", PWDATA); end
        checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL rst_rsp: valid=%0b timeout=%0b expected 0/0", rsp_valid, rsp_timeout);
        end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (irq_rise !== 1'b0)   begin errors++; $display("FAIL rst_irq_rise: got %0b expected 0", irq_rise); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_cmd_ready: got %0b expected 1", cmd_ready); end
        PRESETN = 1'b1;
        last_rdata = 32'h0;
    endtask

    task automatic test_write_zero_wait();
        PREADY = 1'b1;
        send(1'b1, 32'h10, 32'hA5A5_0001, 1, '{to: 1'b0, rdata: last_rdata});
        @(negedge PCLK);  // N+1: SETUP
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
            errors++; $display("FAIL wr_setup: PSEL=%0b PENABLE=%0b expected 1/0", PSEL, PENABLE);
        end
        checks++; if (PADDR !== 32'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wr_fields: PADDR=%h PWRITE=%0b PWDATA=%h expected 10/1/a5a50001", PADDR, PWRITE, PWDATA);
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_busy: cmd_ready got %0b expected 0", cmd_ready); end
        @(negedge PCLK);  // N+2: ACCESS
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++; $display("FAIL wr_access: PSEL=%0b PENABLE=%0b expected 1/1", PSEL, PENABLE);
        end
        @(negedge PCLK);  // N+3: response
        checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++; $display("FAIL wr_done: rsp_valid=%0b cmd_ready=%0b PSEL=%0b expected 1/1/0", rsp_valid, cmd_ready, PSEL);
        end
    endtask

    // Three wait states then PREADY on the 4th ACCESS cycle: this is also the
    // cycle where the TIMEOUT=4 counter expires, so PREADY must win.
    task automatic test_read_wait();
        int n_acc;
        bit got;
        n_acc = 0; got = 0;
        PREADY = 1'b0;
        PRDATA = 32'hDEAD_BEEF;
        send(1'b0, 32'h14, 32'h0, 1, '{to: 1'b0, rdata: 32'hDEAD_BEEF});
        last_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge PCLK);
            if (rsp_valid) got = 1;
            else if (PSEL) begin
                checks++;
                if (PADDR !== 32'h14) begin errors++; $display("FAIL rd_paddr_stable: got %h expected 14", PADDR); end
                if (PENABLE) begin
                    n_acc++;
                    if (n_acc == 4) PREADY = 1'b1;
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rd_rsp_seen: rsp_valid got 0 expected 1 within 30 cycles"); end
        checks++; if (n_acc != 4) begin errors++; $display("FAIL rd_access_len: got %0d cycles expected 4", n_acc); end
    endtask

    task automatic test_timeout();
        int n_acc;
        bit got;
        n_acc = 0; got = 0;
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        send(1'b0, 32'h20, 32'h0, 1, '{to: 1'b1, rdata: 32'h0});
        last_rdata = 32'h0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                got = 1;
                checks++;
                if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
                    errors++; $display("FAIL to_psel_drop: PSEL=%0b PENABLE=%0b expected 0/0", PSEL, PENABLE);
                end
            end else if (PSEL && PENABLE) n_acc++;
        end
        checks++; if (!got) begin errors++; $display("FAIL to_rsp_seen: rsp_valid got 0 expected 1 within 30 cycles"); end
        checks++; if (n_acc != 4) begin errors++; $display("FAIL to_access_len: got %0d cycles expected 4", n_acc); end
        PREADY = 1'b1;
    endtask

    task automatic test_back_to_back();
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_0002;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h1111_2222;
        @(negedge PCLK);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a: got %0b expected 1", cmd_ready); end
        @(posedge PCLK); #1;  // edge N accepted A
        sb_q.push_back('{to: 1'b0, rdata: last_rdata});
        cmd_write = 1'b0; cmd_addr = 32'h34; cmd_wdata = 32'h0;
        @(negedge PCLK);  // N+1
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: cmd_ready got %0b expected 0", cmd_ready); end
        @(negedge PCLK);  // N+2
        @(negedge PCLK);  // N+3
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b1 || PSEL !== 1'b0) begin
            errors++; $display("FAIL b2b_n3: cmd_ready=%0b rsp_valid=%0b PSEL=%0b expected 1/1/0", cmd_ready, rsp_valid, PSEL);
        end
        @(posedge PCLK); #1;  // edge N+3 accepts B
        sb_q.push_back('{to: 1'b0, rdata: 32'hCAFE_0002});
        last_rdata = 32'hCAFE_0002;
        cmd_valid = 1'b0;
        @(negedge PCLK);  // N+4: SETUP of B
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h34 || PWRITE !== 1'b0) begin
            errors++; $display("FAIL b2b_setup_b: PSEL=%0b PENABLE=%0b PADDR=%h PWRITE=%0b expected 1/0/34/0",
                               PSEL, PENABLE, PADDR, PWRITE);
        end
        repeat (3) @(negedge PCLK);
    endtask

    task automatic test_reset_abort();
        bit stray;
        stray = 0;
        PREADY = 1'b0;
        send(1'b1, 32'h40, 32'h5555_AAAA, 0, '{to: 1'b0, rdata: 32'h0});
        @(negedge PCLK);  // SETUP
        @(negedge PCLK);  // ACCESS
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL abort_in_access: PENABLE got %0b expected 1", PENABLE); end
        PRESETN = 1'b0;
        @(negedge PCLK);
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL abort_drop: PSEL=%0b PENABLE=%0b rsp_valid=%0b expected 0/0/0", PSEL, PENABLE, rsp_valid);
        end
        @(negedge PCLK);
        PRESETN = 1'b1;
        PREADY = 1'b1;
        last_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) stray = 1;
        end
        checks++; if (stray) begin errors++; $display("FAIL abort_silent: saw rsp_valid/PSEL after reset, expected none"); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rsp_rdata); end
    endtask

    task automatic test_irq();
        int pulses;
        pulses = 0;
        IRQ = 1'b0;
        repeat (2) @(negedge PCLK);
        IRQ = 1'b1;
        @(negedge PCLK);
        checks++; if (irq_rise !== 1'b1) begin errors++; $display("FAIL irq_pulse: got %0b expected 1", irq_rise); end
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (irq_rise) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL irq_held: got %0d extra pulses expected 0", pulses); end
        IRQ = 1'b0;
        repeat (2) @(negedge PCLK);
        checks++; if (irq_rise !== 1'b0) begin errors++; $display("FAIL irq_fall: got %0b expected 0", irq_rise); end
    endtask

    initial begin
        PRESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b1; IRQ = 1'b0; last_rdata = '0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_irq();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge PCLK);
        @(negedge PCLK);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d responses outstanding expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
